letreiro_scroller: RTL

Upstream sequencer for the scrolling sign. It holds the fixed message "GABRIEL " as 3-bit symbol codes and steps a display window across it at a programmable rate. It drives one 3-bit code per 7-segment digit, and each code feeds a 3-bit symbol decoder instance. Supports run/pause/stop control and left or right scroll direction.

---
 rtl/letreiro_scroller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/letreiro_scroller.sv
// Scrolling-sign sequencer: steps a N_DISP-digit window across "GABRIEL " at a programmable rate.
// Optional blinking of the frozen window during HOLD is enabled by defining LETREIRO_BLINK_EN.
module letreiro_scroller #(
  parameter int N_DISP   = 4,
  parameter int TICK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  dir,
  output logic [3*N_DISP-1:0]   codes,
  output logic [2:0]            pos,
  output logic                  running,
  output logic                  wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  localparam logic [2:0] SYM_SPACE = 3'b101;

  logic [1:0]          state_r, state_s;
  logic [2:0]          pos_r, pos_s;
  logic [PW-1:0]       presc_r, presc_s;
  logic                wrap_r, wrap_s;
  logic                running_r;
  logic                blank_s;
  logic [3*N_DISP-1:0] codes_s;

  // Message ROM: index 0..7 holds g a b r i e l space
  function automatic logic [2:0] msg_sym(input logic [2:0] idx);
    logic [2:0] sym;
    case (idx)
      3'd0:    sym = 3'b110;
      3'd1:    sym = 3'b111;
      3'd2:    sym = 3'b000;
      3'd3:    sym = 3'b001;
      3'd4:    sym = 3'b010;
      3'd5:    sym = 3'b011;
      3'd6:    sym = 3'b100;
      3'd7:    sym = 3'b101;
      default: sym = SYM_SPACE;
    endcase
    return sym;
  endfunction

  // Next-state logic; priority is stop > start > pause > step
  always_comb begin
    state_s = state_r;
    pos_s   = pos_r;
    presc_s = presc_r;
    wrap_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && !stop) begin
          state_s = S_RUN;
          pos_s   = 3'd0;
          presc_s = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN, S_HOLD: begin
        if (stop) begin
          state_s = S_IDLE;
          pos_s   = 3'd0;
          presc_s = '0;
        end else if (start) begin
          state_s = S_RUN;
          pos_s   = 3'd0;
          presc_s = '0;
        end else if (pause) begin
          // a pause landing on terminal count leaves the step pending
          state_s = S_HOLD;
        end else if (state_r == S_HOLD) begin
          state_s = S_RUN;
        end else if (presc_r == TC) begin
          presc_s = '0;
          pos_s   = dir ? (pos_r - 3'd1) : (pos_r + 3'd1);
          wrap_s  = dir ? (pos_r == 3'd0) : (pos_r == 3'd7);
        end else begin
          presc_s = presc_r + PW'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        pos_s   = 3'd0;
        presc_s = '0;
      end
    endcase
  end

  // Control state, position, prescaler and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      pos_r     <= 3'd0;
      presc_r   <= '0;
      wrap_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      pos_r     <= pos_s;
      presc_r   <= presc_s;
      wrap_r    <= wrap_s;
      running_r <= (state_s != S_IDLE);
    end
  end

`ifdef LETREIRO_BLINK_EN
  logic [PW-1:0] blink_cnt_r;
  logic          blink_off_r;

  // Blink phase timer; restarts visible each time HOLD is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end else if ((state_r == S_HOLD) && (state_s == S_HOLD)) begin
      if (blink_cnt_r == TC) begin
        blink_cnt_r <= '0;
        blink_off_r <= ~blink_off_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + PW'(1);
      end
    end else begin
      blink_cnt_r <= '0;
      blink_off_r <= 1'b0;
    end
  end

  assign blank_s = (state_r == S_HOLD) && blink_off_r;
`else
  assign blank_s = 1'b0;
`endif

  // Window decode; digit 0 sits in the MSBs
  always_comb begin
    codes_s = '0;
    for (int k = 0; k < N_DISP; k++) begin
      if ((state_r == S_IDLE) || blank_s) begin
        codes_s[3*(N_DISP-1-k) +: 3] = SYM_SPACE;
      end else begin
        codes_s[3*(N_DISP-1-k) +: 3] = msg_sym(pos_r + 3'(k));
      end
    end
  end

  assign codes   = codes_s;
  assign pos     = pos_r;
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule
